// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//  Shared definitions for the memory arbiter slice: FSM state codes, memory
//  op encodings and the one-hot grant record passed from the priority block
//  to the arbiter FSM.
//
//  Op encoding on mcOp / loadOp / storeOp: {isStore, size[1:0]}
//    size 00 byte, 01 half, 11 word. Instruction fetch always uses FETCH_OP.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // FSM state codes
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_STORE = 2'd3;

    // Op field layout
    localparam int         OP_STORE = 2;        // bit index of the store flag
    localparam logic [1:0] SIZE_B   = 2'b00;
    localparam logic [1:0] SIZE_H   = 2'b01;
    localparam logic [1:0] SIZE_W   = 2'b11;
    localparam logic [2:0] FETCH_OP = {1'b0, SIZE_W};

    // One-hot grant decision for the current IDLE cycle
    typedef struct packed {
        logic store;
        logic load;
        logic fetch;
    } grant_t;

    // True for the states whose transaction returns read data and can be
    // aborted by a flush.
    function automatic logic isReadState(input logic [1:0] state);
        return (state == ST_FETCH) || (state == ST_LOAD);
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// ---------------------------------------------------------------------------
// mem_arb_prio
//  Grant selection for the memory arbiter plus the fetch starvation counter.
//
//  Priority (only when grantEnable is high):
//    1 store  (committed stores must drain in order)
//    2 fetch  when the starve counter has reached STARVE_LIMIT
//    3 load
//    4 fetch
//
//  Ports
//    clockIn      system clock
//    resetIn      synchronous active-high reset
//    readyIn      global enable, counter holds when low
//    grantEnable  arbiter is in IDLE and may start a transaction this cycle
//    clearIdle    flush seen while IDLE, resets the starve counter
//    fetchReq/loadReq/storeReq  raw requester lines
//    grant        one-hot grant decision (combinational)
// ---------------------------------------------------------------------------
module mem_arb_prio
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic   clockIn,
    input  logic   resetIn,
    input  logic   readyIn,
    input  logic   grantEnable,
    input  logic   clearIdle,
    input  logic   fetchReq,
    input  logic   loadReq,
    input  logic   storeReq,
    output grant_t grant
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starveCntReg;
    logic       fetchStarved;

    assign fetchStarved = (starveCntReg == LIMIT);

    always_comb begin
        grant = '0;
        if (grantEnable) begin
            if (storeReq) begin
                grant.store = 1'b1;
            end else if (fetchReq && fetchStarved) begin
                grant.fetch = 1'b1;
            end else if (loadReq) begin
                grant.load = 1'b1;
            end else if (fetchReq) begin
                grant.fetch = 1'b1;
            end
        end
    end

    // Counts data-side grants that overtook a waiting fetch. Any moment
    // without a pending fetch, or the fetch finally being granted, restarts
    // the count.
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            starveCntReg <= '0;
        end else if (readyIn) begin
            if (clearIdle || !fetchReq || grant.fetch) begin
                starveCntReg <= '0;
            end else if ((grant.load || grant.store) && !fetchStarved) begin
                starveCntReg <= starveCntReg + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//  Schedules the single-port memory controller between icache fetch, LSB
//  load and committed-store drain, with anti-starvation for fetch and the
//  branch-flush cancel rules.
//
//  Optional feature: define ARB_PERF_EN to add three free-running 32-bit
//  performance counters (perfFetchWait, perfLoadWait, perfStoreCnt) and the
//  matching output ports.
//
//  Ports
//    clockIn, resetIn    clock, synchronous active-high reset
//    readyIn             global enable; low freezes every register/output
//    clearIn             mispredict flush (aborts fetch/load, not stores)
//    fetchReq/fetchAddr/fetchDone           icache side
//    loadReq/loadOp/loadAddr/loadDone       LSB load side
//    storeReq/storeOp/storeAddr/storeData/storeDone   store drain side
//    rdata               registered read data for fetch/load
//    mcFlag/mcOp/mcIsFetch/mcAddr/mcData/mcClear      to memory controller
//    mcOk/mcRdata        completion pulse and read data from controller
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clockIn,
    input  logic        resetIn,
    input  logic        readyIn,
    input  logic        clearIn,
    input  logic        fetchReq,
    input  logic [31:0] fetchAddr,
    output logic        fetchDone,
    input  logic        loadReq,
    input  logic [2:0]  loadOp,
    input  logic [31:0] loadAddr,
    output logic        loadDone,
    input  logic        storeReq,
    input  logic [2:0]  storeOp,
    input  logic [31:0] storeAddr,
    input  logic [31:0] storeData,
    output logic        storeDone,
    output logic [31:0] rdata,
    output logic        mcFlag,
    output logic [2:0]  mcOp,
    output logic        mcIsFetch,
    output logic [31:0] mcAddr,
    output logic [31:0] mcData,
    output logic        mcClear,
    input  logic        mcOk,
`ifdef ARB_PERF_EN
    output logic [31:0] perfFetchWait,
    output logic [31:0] perfLoadWait,
    output logic [31:0] perfStoreCnt,
`endif
    input  logic [31:0] mcRdata
);

    logic [1:0] stateReg;
    grant_t     grant;
    logic       anyDone;
    logic       grantEnable;
    logic       clearIdle;

    // The cycle that carries a Done pulse is the mandatory IDLE gap: the
    // finished requester still shows its request here, so granting now
    // would replay it.
    assign anyDone     = fetchDone | loadDone | storeDone;
    assign grantEnable = (stateReg == ST_IDLE) && !clearIn && !anyDone;
    assign clearIdle   = (stateReg == ST_IDLE) && clearIn;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .readyIn     (readyIn),
        .grantEnable (grantEnable),
        .clearIdle   (clearIdle),
        .fetchReq    (fetchReq),
        .loadReq     (loadReq),
        .storeReq    (storeReq),
        .grant       (grant)
    );

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            stateReg  <= ST_IDLE;
            mcFlag    <= 1'b0;
            mcOp      <= '0;
            mcIsFetch <= 1'b0;
            mcAddr    <= '0;
            mcData    <= '0;
            mcClear   <= 1'b0;
            rdata     <= '0;
            fetchDone <= 1'b0;
            loadDone  <= 1'b0;
            storeDone <= 1'b0;
        end else if (readyIn) begin
            // Pulses last exactly one ready cycle
            fetchDone <= 1'b0;
            loadDone  <= 1'b0;
            storeDone <= 1'b0;
            mcClear   <= 1'b0;

            case (stateReg)
                ST_IDLE: begin
                    if (grant.store) begin
                        mcOp      <= storeOp;
                        mcAddr    <= storeAddr;
                        mcData    <= storeData;
                        mcIsFetch <= 1'b0;
                        mcFlag    <= 1'b1;
                        stateReg  <= ST_STORE;
                    end else if (grant.fetch) begin
                        mcOp      <= FETCH_OP;
                        mcAddr    <= fetchAddr;
                        mcData    <= '0;
                        mcIsFetch <= 1'b1;
                        mcFlag    <= 1'b1;
                        stateReg  <= ST_FETCH;
                    end else if (grant.load) begin
                        mcOp      <= loadOp;
                        mcAddr    <= loadAddr;
                        mcData    <= '0;
                        mcIsFetch <= 1'b0;
                        mcFlag    <= 1'b1;
                        stateReg  <= ST_LOAD;
                    end
                end

                ST_FETCH, ST_LOAD: begin
                    // A flush beats a simultaneous completion: the data
                    // belongs to a squashed path and must not be reported.
                    if (clearIn) begin
                        mcClear  <= 1'b1;
                        mcFlag   <= 1'b0;
                        stateReg <= ST_IDLE;
                    end else if (mcOk) begin
                        mcFlag    <= 1'b0;
                        rdata     <= mcRdata;
                        fetchDone <= (stateReg == ST_FETCH);
                        loadDone  <= (stateReg == ST_LOAD);
                        stateReg  <= ST_IDLE;
                    end
                end

                ST_STORE: begin
                    // Stores are already committed; a flush never cancels them.
                    if (mcOk) begin
                        mcFlag    <= 1'b0;
                        storeDone <= 1'b1;
                        stateReg  <= ST_IDLE;
                    end
                end

                default: stateReg <= ST_IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            perfFetchWait <= '0;
            perfLoadWait  <= '0;
            perfStoreCnt  <= '0;
        end else if (readyIn) begin
            if (fetchReq && (stateReg != ST_FETCH)) begin
                perfFetchWait <= perfFetchWait + 32'd1;
            end
            if (loadReq && (stateReg != ST_LOAD)) begin
                perfLoadWait <= perfLoadWait + 32'd1;
            end
            if ((stateReg == ST_STORE) && mcOk) begin
                perfStoreCnt <= perfStoreCnt + 32'd1;
            end
        end
    end
`endif

    // Read-state helper keeps the busy decode in one place for reviewers
    // cross-checking the flush behaviour; it has no effect on logic above.
    logic unusedReadState;
    assign unusedReadState = isReadState(stateReg) & 1'b0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//  Self-checking bench for mem_arbiter (STARVE_LIMIT = 4). Table-driven
//  single transactions plus hand-written multi-cycle sequences; expected
//  memory-controller transactions are queued when a request is driven and
//  popped when mcFlag rises.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clockIn = 1'b0;
    logic        resetIn, readyIn, clearIn;
    logic        fetchReq, loadReq, storeReq, mcOk;
    logic [31:0] fetchAddr, loadAddr, storeAddr, storeData, mcRdata;
    logic [2:0]  loadOp, storeOp;
    logic        fetchDone, loadDone, storeDone;
    logic [31:0] rdata, mcAddr, mcData;
    logic [2:0]  mcOp;
    logic        mcFlag, mcIsFetch, mcClear;
`ifdef ARB_PERF_EN
    logic [31:0] perfFetchWait, perfLoadWait, perfStoreCnt;
`endif

    always #5 clockIn = ~clockIn;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clockIn   (clockIn),
        .resetIn   (resetIn),
        .readyIn   (readyIn),
        .clearIn   (clearIn),
        .fetchReq  (fetchReq),
        .fetchAddr (fetchAddr),
        .fetchDone (fetchDone),
        .loadReq   (loadReq),
        .loadOp    (loadOp),
        .loadAddr  (loadAddr),
        .loadDone  (loadDone),
        .storeReq  (storeReq),
        .storeOp   (storeOp),
        .storeAddr (storeAddr),
        .storeData (storeData),
        .storeDone (storeDone),
        .rdata     (rdata),
        .mcFlag    (mcFlag),
        .mcOp      (mcOp),
        .mcIsFetch (mcIsFetch),
        .mcAddr    (mcAddr),
        .mcData    (mcData),
        .mcClear   (mcClear),
        .mcOk      (mcOk),
`ifdef ARB_PERF_EN
        .perfFetchWait (perfFetchWait),
        .perfLoadWait  (perfLoadWait),
        .perfStoreCnt  (perfStoreCnt),
`endif
        .mcRdata   (mcRdata)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        isFetch;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chkData;
    } txn_t;
    txn_t sbQ[$];

    // kind: 0 fetch, 1 load, 2 store
    typedef struct {
        logic        f, l, s;
        logic [31:0] fAddr;
        logic [2:0]  lOp;
        logic [31:0] lAddr;
        logic [2:0]  sOp;
        logic [31:0] sAddr, sData;
        int          delay;
        logic [31:0] rd;
        int          expKind;
        logic [2:0]  expOp;
        logic [31:0] expAddr;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clockIn);
        #1;
    endtask

    task automatic push(input logic isF, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic chkD);
        txn_t t;
        t.isFetch = isF; t.op = op; t.addr = addr; t.data = data; t.chkData = chkD;
        sbQ.push_back(t);
    endtask

    // Wait (bounded) for mcFlag, then compare the presented transaction
    // against the oldest scoreboard entry.
    task automatic grantCheck(input string name, input int expLat);
        int   lat;
        txn_t e;
        lat = 0;
        while (!mcFlag && lat < 50) begin
            step();
            lat++;
        end
        check({name, " mcFlag"}, 32'(mcFlag), 32'd1);
        if (expLat >= 0) check({name, " latency"}, 32'(lat), 32'(expLat));
        if (sbQ.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL %s: scoreboard empty, got addr 0x%08h", name, mcAddr);
        end else begin
            e = sbQ.pop_front();
            check({name, " mcIsFetch"}, 32'(mcIsFetch), 32'(e.isFetch));
            check({name, " mcOp"}, 32'(mcOp), 32'(e.op));
            check({name, " mcAddr"}, mcAddr, e.addr);
            if (e.chkData) check({name, " mcData"}, mcData, e.data);
            $display("txn %s: isFetch=%0d op=%03b addr=0x%08h data=0x%08h",
                     name, mcIsFetch, mcOp, mcAddr, mcData);
        end
    endtask

    task automatic serve(input int delay, input logic [31:0] rd);
        repeat (delay) step();
        mcOk    = 1'b1;
        mcRdata = rd;
        step();
        mcOk    = 1'b0;
        mcRdata = '0;
    endtask

    task automatic doneCheck(input string name, input int kind, input logic [31:0] rd);
        check({name, " fetchDone"}, 32'(fetchDone), 32'(kind == 0));
        check({name, " loadDone"},  32'(loadDone),  32'(kind == 1));
        check({name, " storeDone"}, 32'(storeDone), 32'(kind == 2));
        check({name, " mcFlag low"}, 32'(mcFlag), 32'd0);
        if (kind != 2) check({name, " rdata"}, rdata, rd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0,
                    5, 32'hDEADBEEF, 0, 3'b011, 32'h100};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, {1'b0, SIZE_B}, 32'h2001, 3'b000, 32'h0, 32'h0,
                    1, 32'h000000A5, 1, 3'b000, 32'h2001};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, {1'b0, SIZE_W}, 32'h3000, 3'b000, 32'h0, 32'h0,
                    0, 32'hCAFEF00D, 1, 3'b011, 32'h3000};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0, 3'b000, 32'h0, {1'b1, SIZE_H}, 32'h4002, 32'h0000BEEF,
                    2, 32'h0, 2, 3'b101, 32'h4002};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h140, 3'b011, 32'h3004, 3'b111, 32'h5000, 32'h12345678,
                    3, 32'h0, 2, 3'b111, 32'h5000};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h180, {1'b0, SIZE_H}, 32'h6000, 3'b000, 32'h0, 32'h0,
                    1, 32'h00001234, 1, 3'b001, 32'h6000};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h1C0, 3'b000, 32'h0, 3'b100, 32'h7003, 32'h000000EE,
                    0, 32'h0, 2, 3'b100, 32'h7003};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0,
                    2, 32'h0BADC0DE, 0, 3'b011, 32'hFFFFFFFC};

        resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0;
        fetchReq = 1'b0; loadReq = 1'b0; storeReq = 1'b0; mcOk = 1'b0;
        fetchAddr = '0; loadAddr = '0; storeAddr = '0; storeData = '0; mcRdata = '0;
        loadOp = '0; storeOp = '0;
        repeat (3) step();
        resetIn = 1'b0;
        step();

        // Reset state
        check("reset mcFlag",    32'(mcFlag),    32'd0);
        check("reset mcIsFetch", 32'(mcIsFetch), 32'd0);
        check("reset mcOp",      32'(mcOp),      32'd0);
        check("reset mcAddr",    mcAddr,         32'd0);
        check("reset mcData",    mcData,         32'd0);
        check("reset mcClear",   32'(mcClear),   32'd0);
        check("reset rdata",     rdata,          32'd0);
        check("reset dones",     32'({fetchDone, loadDone, storeDone}), 32'd0);

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            fetchReq = vecs[i].f; fetchAddr = vecs[i].fAddr;
            loadReq  = vecs[i].l; loadOp    = vecs[i].lOp;  loadAddr = vecs[i].lAddr;
            storeReq = vecs[i].s; storeOp   = vecs[i].sOp;  storeAddr = vecs[i].sAddr;
            storeData = vecs[i].sData;
            push(vecs[i].expKind == 0, vecs[i].expOp, vecs[i].expAddr, vecs[i].sData,
                 vecs[i].expKind == 2);
            grantCheck($sformatf("vec%0d", i), 1);
            serve(vecs[i].delay, vecs[i].rd);
            doneCheck($sformatf("vec%0d", i), vecs[i].expKind, vecs[i].rd);
            fetchReq = 1'b0; loadReq = 1'b0; storeReq = 1'b0;
            step();
            check($sformatf("vec%0d done width", i),
                  32'({fetchDone, loadDone, storeDone}), 32'd0);
            step();
        end

        // Starvation: fetch waits behind back-to-back loads
        fetchReq = 1'b1; fetchAddr = 32'h700;
        loadReq  = 1'b1; loadOp = 3'b011; loadAddr = 32'h800;
        for (int i = 0; i < 4; i++) push(1'b0, 3'b011, 32'h800, 32'h0, 1'b0);
        push(1'b1, 3'b011, 32'h700, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            grantCheck($sformatf("starve%0d", i), (i == 0) ? 1 : -1);
            serve(1, 32'h100 + 32'(i));
            doneCheck($sformatf("starve%0d", i), (i == 4) ? 0 : 1, 32'h100 + 32'(i));
        end
        fetchReq = 1'b0; loadReq = 1'b0;
        step(); step();

        // Flush during LOAD: abort, no loadDone
        loadReq = 1'b1; loadOp = 3'b010; loadAddr = 32'h900;
        push(1'b0, 3'b010, 32'h900, 32'h0, 1'b0);
        grantCheck("clrLoad", 1);
        step();
        clearIn = 1'b1; loadReq = 1'b0;
        step();
        clearIn = 1'b0;
        check("clrLoad mcClear", 32'(mcClear), 32'd1);
        check("clrLoad mcFlag",  32'(mcFlag),  32'd0);
        check("clrLoad loadDone", 32'(loadDone), 32'd0);
        step();
        check("clrLoad mcClear width", 32'(mcClear), 32'd0);
        check("clrLoad no done", 32'({fetchDone, loadDone, storeDone}), 32'd0);
        check("clrLoad idle", 32'(mcFlag), 32'd0);
        step();

        // Flush during STORE: store still completes
        storeReq = 1'b1; storeOp = 3'b111; storeAddr = 32'hA00; storeData = 32'hA5A5A5A5;
        push(1'b0, 3'b111, 32'hA00, 32'hA5A5A5A5, 1'b1);
        grantCheck("clrStore", 1);
        clearIn = 1'b1;
        step();
        clearIn = 1'b0;
        check("clrStore mcClear", 32'(mcClear), 32'd0);
        check("clrStore mcFlag",  32'(mcFlag),  32'd1);
        serve(1, 32'h0);
        doneCheck("clrStore", 2, 32'h0);
        storeReq = 1'b0;
        step(); step();

        // readyIn low for 3 cycles mid-FETCH with mcOk held
        fetchReq = 1'b1; fetchAddr = 32'hB00;
        push(1'b1, 3'b011, 32'hB00, 32'h0, 1'b0);
        grantCheck("stall", 1);
        readyIn = 1'b0; mcOk = 1'b1; mcRdata = 32'h55AA55AA;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall%0d mcFlag", i), 32'(mcFlag), 32'd1);
            check($sformatf("stall%0d fetchDone", i), 32'(fetchDone), 32'd0);
        end
        readyIn = 1'b1;
        step();
        mcOk = 1'b0; mcRdata = '0;
        doneCheck("stall", 0, 32'h55AA55AA);
        fetchReq = 1'b0;
        step(); step();

        // mcOk and clearIn together in FETCH: clear wins, fetch re-issued
        fetchReq = 1'b1; fetchAddr = 32'hC00;
        push(1'b1, 3'b011, 32'hC00, 32'h0, 1'b0);
        grantCheck("okClr", 1);
        step();
        mcOk = 1'b1; mcRdata = 32'h11111111; clearIn = 1'b1;
        step();
        mcOk = 1'b0; mcRdata = '0; clearIn = 1'b0;
        check("okClr mcClear",   32'(mcClear),   32'd1);
        check("okClr fetchDone", 32'(fetchDone), 32'd0);
        check("okClr mcFlag",    32'(mcFlag),    32'd0);
        fetchAddr = 32'hD00;
        push(1'b1, 3'b011, 32'hD00, 32'h0, 1'b0);
        grantCheck("okClrRe", 1);
        serve(0, 32'h22222222);
        doneCheck("okClrRe", 0, 32'h22222222);
        fetchReq = 1'b0;
        step(); step();

        // Reset mid-transaction
        fetchReq = 1'b1; fetchAddr = 32'hE00;
        push(1'b1, 3'b011, 32'hE00, 32'h0, 1'b0);
        grantCheck("rstMid", 1);
        resetIn = 1'b1;
        step();
        check("rstMid mcFlag",    32'(mcFlag),    32'd0);
        check("rstMid mcIsFetch", 32'(mcIsFetch), 32'd0);
        check("rstMid mcAddr",    mcAddr,         32'd0);
        resetIn = 1'b0; fetchReq = 1'b0;
        step(); step();
        check("rstMid idle", 32'(mcFlag), 32'd0);
        check("scoreboard drained", 32'(sbQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
